// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - MSB-first serial pattern transmitter with repeat count
// Optional inter-frame gap cycle: define SERIAL_TX_GAP_EN.
module serial_pattern_tx #(
   parameter int PAT_WIDTH = 4,
   parameter int CNT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 start,
   input  logic [PAT_WIDTH-1:0] pattern,
   input  logic [CNT_WIDTH-1:0] repeat_cnt,
   output logic                 o,
   output logic                 o_valid,
   output logic                 busy,
   output logic                 done
);

   localparam int BW = $clog2(PAT_WIDTH);
   localparam logic [BW-1:0] LAST_IDX = BW'(PAT_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
`ifdef SERIAL_TX_GAP_EN
      GAP   = 2'd2,
`endif
      DONE  = 2'd3
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic [PAT_WIDTH-1:0] shift_reg;
   logic [PAT_WIDTH-1:0] pat_copy;
   logic [CNT_WIDTH-1:0] reps;
   logic [BW-1:0]        bit_cnt;
   logic                 last_bit;

   assign last_bit = (bit_cnt == LAST_IDX);

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      o        = 1'b0;
      o_valid  = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = SHIFT;
         end
         SHIFT: begin
            o       = shift_reg[PAT_WIDTH-1];
            o_valid = 1'b1;
            busy    = 1'b1;
            if (last_bit) begin
               if (reps != '0) begin
`ifdef SERIAL_TX_GAP_EN
                  state_nx = GAP;
`else
                  state_nx = SHIFT;
`endif
               end else begin
                  state_nx = DONE;
               end
            end
         end
`ifdef SERIAL_TX_GAP_EN
         GAP: begin
            busy     = 1'b1;
            state_nx = SHIFT;
         end
`endif
         DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // The next frame is reloaded on the last bit so a gap cycle only has to hold.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         shift_reg <= '0;
         pat_copy  <= '0;
         reps      <= '0;
         bit_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shift_reg <= pattern;
                  pat_copy  <= pattern;
                  reps      <= repeat_cnt;
                  bit_cnt   <= '0;
               end
            end
            SHIFT: begin
               if (last_bit && reps != '0) begin
                  reps      <= reps - 1'b1;
                  shift_reg <= pat_copy;
                  bit_cnt   <= '0;
               end else if (last_bit) begin
                  shift_reg <= {shift_reg[PAT_WIDTH-2:0], 1'b0};
                  bit_cnt   <= '0;
               end else begin
                  shift_reg <= {shift_reg[PAT_WIDTH-2:0], 1'b0};
                  bit_cnt   <= bit_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - randomized bench for serial_pattern_tx against a per-cycle output queue model
module tb_serial_pattern_tx;

`ifdef SERIAL_TX_GAP_EN
   localparam bit GAP_ON = 1'b1;
`else
   localparam bit GAP_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       start = 1'b0;
   logic [3:0] pattern = 4'h0;
   logic [3:0] repeat_cnt = 4'h0;
   logic       o;
   logic       o_valid;
   logic       busy;
   logic       done;

   int total = 0;
   int bad = 0;

   // Each entry is the expected {o, o_valid, busy, done} for one cycle.
   logic [3:0] exp_q[$];
   logic [3:0] det_win = 4'h0;
   int         det_bits = 0;
   int         det_hits = 0;
   int         busy_run = 0;

   serial_pattern_tx #(.PAT_WIDTH(4), .CNT_WIDTH(4)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .pattern(pattern),
      .repeat_cnt(repeat_cnt), .o(o), .o_valid(o_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic push_transfer(input logic [3:0] p, input logic [3:0] r);
      for (int f = 0; f <= int'(r); f++) begin
         for (int j = 3; j >= 0; j--) exp_q.push_back({p[j], 1'b1, 1'b1, 1'b0});
         if (GAP_ON && f < int'(r)) exp_q.push_back(4'b0010);
      end
      exp_q.push_back(4'b0011);
      exp_q.push_back(4'b0000);
   endtask

   task automatic tick(input logic s, input logic [3:0] p, input logic [3:0] r, input logic rn);
      logic [3:0] e;
      start = s; pattern = p; repeat_cnt = r; n_rst = rn;
      @(posedge clk);
      if (!rn) exp_q.delete();
      else if (exp_q.size() == 0 && s) push_transfer(p, r);
      #1;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b0000;
      check_eq("o", o, e[3]);
      check_eq("o_valid", o_valid, e[2]);
      check_eq("busy", busy, e[1]);
      check_eq("done", done, e[0]);
      if (o_valid) begin
         det_win = {det_win[2:0], o};
         det_bits++;
         if (det_bits >= 4 && det_win == 4'b1101) det_hits++;
      end else begin
         det_bits = 0;
      end
      busy_run = busy ? busy_run + 1 : busy_run;
   endtask

   initial begin
      logic [3:0] rp;
      logic [3:0] rr;
      // Reset then idle
      tick(0, 4'h0, 4'h0, 0);
      tick(0, 4'h0, 4'h0, 0);
      repeat (3) tick(0, 4'h0, 4'h0, 1);

      // Single frame 1101
      busy_run = 0;
      tick(1, 4'b1101, 4'd0, 1);
      repeat (7) tick(0, 4'h0, 4'h0, 1);
      check_eq("busy_cycles_single", busy_run, 5);

      // Three frames of 1101; detector should fire once per frame
      busy_run = 0; det_hits = 0;
      tick(1, 4'b1101, 4'd2, 1);
      repeat (17) tick(0, 4'h0, 4'h0, 1);
      check_eq("det_hits", det_hits, 3);
      check_eq("busy_cycles_rep2", busy_run, GAP_ON ? 15 : 13);

      // Start pulse and pattern change while shifting are ignored
      tick(1, 4'b1101, 4'd0, 1);
      tick(1, 4'b0000, 4'd5, 1);
      tick(0, 4'b0000, 4'd0, 1);
      repeat (6) tick(0, 4'b0000, 4'd0, 1);

      // Reset during the third bit of 1011, then resend cleanly
      tick(1, 4'b1011, 4'd0, 1);
      tick(0, 4'h0, 4'h0, 1);
      tick(0, 4'h0, 4'h0, 1);
      tick(0, 4'h0, 4'h0, 0);
      repeat (4) tick(0, 4'h0, 4'h0, 1);
      tick(1, 4'b1011, 4'd0, 1);
      repeat (6) tick(0, 4'h0, 4'h0, 1);

      // Back-to-back transfers with start held high
      repeat (12) tick(1, 4'b0110, 4'd0, 1);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         rp = 4'($urandom);
         rr = 4'($urandom_range(0, 3));
         tick(($urandom_range(0, 3) == 0), rp, rr, ($urandom_range(0, 79) != 0));
      end
      repeat (25) tick(0, 4'h0, 4'h0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial pattern transmitter that drives a programmable bit pattern MSB-first onto a one-bit line, one bit per clock, optionally repeated. It is the transmit end of the serial sequence path. Its output feeds a sequence detector (e.g. a "1101" detector) directly, and it generates detector stimulus on-chip. A start pulse loads the pattern. A busy flag and a done pulse report progress.

## Interface
- PAT_WIDTH, 4, number of bits in one pattern frame (≥2)
- CNT_WIDTH, 4, width of the repeat-count input
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  synchronous, active-low reset, sampled on rising edge of clk
- start  input  1  request to begin transmission, sampled only in IDLE
- pattern  input  PAT_WIDTH  frame to send, captured when start is accepted
- repeat_cnt  input  CNT_WIDTH  additional repetitions, captured with pattern (frames sent = repeat_cnt+1)
- o  output  1  serial data bit
- o_valid  output  1  high while o carries a pattern bit
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse after the final bit

## Operation
- States: IDLE, SHIFT, GAP (GAP_EN only), DONE.
- All outputs are Moore outputs, decoded from registered state, shift register and counters only.
- No input feeds an output combinationally.
- IDLE:
  - o=0, o_valid=0, busy=0, done=0.
  - If start=1: latch pattern into the shift register and into a pattern copy register, latch repeat_cnt into reps, clear the bit counter, and go to SHIFT.
- SHIFT:
  - o = shift register MSB, o_valid=1, busy=1.
  - Each cycle: shift left by one, bit counter +1.
  - After the bit at index PAT_WIDTH-1 (last bit of the frame):
    - reps≠0: decrement reps, reload the shift register from the pattern copy, clear the bit counter. Go to GAP if GAP_EN is defined, otherwise stay in SHIFT.
    - reps=0: go to DONE.
- GAP: o=0, o_valid=0, busy=1. Lasts exactly one cycle, then SHIFT.
- DONE: o=0, o_valid=0, busy=1, done=1. Lasts exactly one cycle, then IDLE.
- start is ignored in SHIFT, GAP and DONE. It is not queued.
- pattern and repeat_cnt are don't-care except in the cycle start is accepted. Later changes do not affect the frame in flight.
- Bit counter width is $clog2(PAT_WIDTH). reps is CNT_WIDTH bits and never wraps: it is decremented only when non-zero.

## Timing
- Reset: n_rst=0 at a rising edge forces state IDLE, shift register 0, reps 0, bit counter 0. From that edge, o=0, o_valid=0, busy=0, done=0.
- Reset mid-transfer aborts immediately: no done pulse, no further bits.
- Latency: start=1 in IDLE at edge k puts pattern[PAT_WIDTH-1] on o in the cycle following edge k.
- Frame i bit j appears exactly one cycle after bit j-1. Frames are back-to-back without GAP_EN.
- Total busy cycles:
  - without GAP_EN: PAT_WIDTH·(repeat_cnt+1)+1
  - with GAP_EN: PAT_WIDTH·(repeat_cnt+1)+repeat_cnt+1
- done is high for exactly one cycle, immediately after the last o_valid cycle.
- The earliest next accepted start is on the edge that ends the cycle after done, i.e. the first IDLE cycle.
- start held high continuously yields back-to-back transfers with one IDLE cycle between done and the next first bit.

## Configuration
- SERIAL_TX_GAP_EN defined: one GAP cycle (o=0, o_valid=0) separates consecutive frames. The GAP state and its transitions exist.
- SERIAL_TX_GAP_EN undefined: the GAP state is not compiled in and frames are contiguous.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use PAT_WIDTH=4.
- Reset, then idle: n_rst low 2 cycles, start=0 → o=0, o_valid=0, busy=0, done=0 every cycle.
- Single frame: pattern=4'b1101, repeat_cnt=0, start pulse → o=1,1,0,1 with o_valid=1 over 4 consecutive cycles. Then done=1 for 1 cycle, then busy=0. busy high for 5 cycles.
- Repeat, no gap: pattern=4'b1101, repeat_cnt=2 → 12 contiguous valid bits 110111011101, then done. An attached 1101 detector asserts 3 times.
- Repeat with SERIAL_TX_GAP_EN: pattern=4'b1101, repeat_cnt=2 → bits 1101,gap,1101,gap,1101 with o_valid=0 in the 2 gap cycles. busy high for 15 cycles.
- Ignored inputs:
  - start pulsed during SHIFT → no restart and no extra frame.
  - pattern changed to 4'b0000 after acceptance → transmitted bits still 1101.
- Reset mid-operation: n_rst=0 during the 3rd bit of a 4'b1011 frame → from that edge o=0, o_valid=0, busy=0, and done never pulses. A new start after release sends 1011 cleanly.
